serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell plus a registered borrow.
- Serves as the sequential, area-lean counterpart to the team's combinational adder datapath.
- Sits behind a start/busy/done handshake for use by small controllers.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      asynchronous active-low reset
- start   input   1      request; sampled only in IDLE
- a       input   WIDTH  minuend; captured on accepted start
- b       input   WIDTH  subtrahend; captured on accepted start
- busy    output  1      high while bits are being processed (RUN)
- done    output  1      one-cycle pulse; diff/borrow valid from this cycle
- diff    output  WIDTH  result a - b modulo 2^WIDTH; registered
- borrow  output  1      1 when a < b unsigned; registered
- ovf     output  1      signed overflow; present only with SERIAL_SUB_OVF_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0, all state and outputs are 0 (state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0).
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - On start=1, capture a and b into shift registers sa and sb.
  - Clear the internal borrow register bw and the bit counter cnt (width clog2(WIDTH+1)). Clear the internal result shift register sd.
  - Go to RUN. busy=1 from the next cycle.
- RUN, each edge:
  - d = sa[0]^sb[0]^bw
  - bw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bw)
  - sd <= {d, sd[WIDTH-1:1]}; sa and sb shift right by 1; cnt <= cnt+1.
  - On the edge where the WIDTH-th bit is processed (cnt==WIDTH-1):
    - diff <= final sd value (including that bit);
    - borrow <= final bw;
    - go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start accepted at edge k. Bits are processed at edges k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- Throughput: start held high gives one result every WIDTH+2 cycles; the next start is accepted at the edge after DONE.
- start in RUN or DONE is ignored; no queueing. a and b may change freely after acceptance without effect.
- diff, borrow and ovf change only on the RUN->DONE edge or on reset. They hold their values through IDLE and the next RUN.
- Reset asserted mid-RUN: operation is aborted and all outputs return to 0 immediately. After release the block is in IDLE and needs a new start.
- a == b gives diff=0, borrow=0. Any a minus b=0 gives diff=a, borrow=0.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined:
  - Port ovf exists.
  - Operand MSBs a[WIDTH-1] and b[WIDTH-1] are latched at start.
  - At RUN->DONE: ovf <= (aMSB != bMSB) && (final d != aMSB), i.e. two's-complement overflow of a - b.
  - ovf follows the same hold and reset rules as diff.
- When undefined: port ovf and the MSB latches are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, single start pulse -> busy high for 8 cycles; done pulses 9 cycles after the accept edge; diff=0x23, borrow=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1; with SERIAL_SUB_OVF_EN, ovf=0.
- a=0x80, b=0x01 with SERIAL_SUB_OVF_EN -> diff=0x7F, borrow=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- start=1 held continuously with a=0x10, b=0x01 -> done pulses every 10 cycles, each with diff=0x0F. Changing a to 0x20 mid-RUN does not affect the current result; the next result is 0x1F.
- Start a=0xAA, b=0x55, pulse start again at RUN cycle 3 -> the second start is ignored; the single done gives diff=0x55, borrow=0.
- Assert rst_n=0 at RUN cycle 4 -> busy, done, diff and borrow are 0 at once. After release there is no done until a new start, e.g. a=0x03, b=0x05 -> diff=0xFE, borrow=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor bit per clock behind a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d_bit;
    logic             bw_nxt;
    logic [WIDTH-1:0] sd_nxt;
    logic             last_bit;

    // The bit shifted out of sd is always a cleared zero, never a result bit.
    logic             unused_sd_lsb;
    assign unused_sd_lsb = sd_q[0];

`ifdef SERIAL_SUB_OVF_EN
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;
`endif

    // Single full-subtractor cell
    assign d_bit    = sa_q[0] ^ sb_q[0] ^ bw_q;
    assign bw_nxt   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    assign sd_nxt   = {d_bit, sd_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d  = a;
                    sb_d  = b;
                    sd_d  = '0;
                    bw_d  = 1'b0;
                    cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d = a[WIDTH-1];
                    bmsb_d = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_nxt;
                bw_d  = bw_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d   = sd_nxt;
                    borrow_d = bw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // The last d is the result sign bit.
                    ovf_d = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference model at accept time, negedge monitor compares.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer subtraction in unsigned and signed views
    function automatic exp_t ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t   e;
        longint sx, sy, r;
        e.diff   = x - y;
        e.borrow = (x < y);
        sx = x[WIDTH-1] ? longint'(x) - (64'sd1 <<< WIDTH) : longint'(x);
        sy = y[WIDTH-1] ? longint'(y) - (64'sd1 <<< WIDTH) : longint'(y);
        r  = sx - sy;
        e.ovf = (r > (64'sd1 <<< (WIDTH - 1)) - 1) || (r < -(64'sd1 <<< (WIDTH - 1)));
        return e;
    endfunction

    // Timing model: edge counter, last accepted edge, expected held outputs
    exp_t sb_q[$];
    exp_t cur_exp;
    int   cyc = 0;
    int   acc = -1000;
    logic [WIDTH-1:0] hold_diff = '0;
    logic hold_borrow = 1'b0;
    logic hold_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            acc         = -1000;
            hold_diff   = '0;
            hold_borrow = 1'b0;
            hold_ovf    = 1'b0;
        end else begin
            cyc++;
            if (cyc == acc + WIDTH) begin
                hold_diff   = cur_exp.diff;
                hold_borrow = cur_exp.borrow;
                hold_ovf    = cur_exp.ovf;
            end
            if (start && cyc >= acc + WIDTH + 2) begin
                acc     = cyc;
                cur_exp = ref_sub(a, b);
                sb_q.push_back(cur_exp);
            end
        end
    end

    // Monitor: timing of busy/done, held outputs, and scoreboard pop on done
    always @(negedge clk) begin
        exp_t e;
        chk("busy", 64'(busy), 64'((cyc >= acc) && (cyc <= acc + WIDTH - 1)));
        chk("done", 64'(done), 64'(cyc == acc + WIDTH));
        chk("diff_hold", 64'(diff), 64'(hold_diff));
        chk("borrow_hold", 64'(borrow), 64'(hold_borrow));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_hold", 64'(ovf), 64'(hold_ovf));
`endif
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty at %0t: done with no expected result", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_diff", 64'(diff), 64'(e.diff));
                chk("sb_borrow", 64'(borrow), 64'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
                chk("sb_ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc >= acc + WIDTH + 1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout at %0t: block never returned idle", $time);
        end
    endtask

    task automatic pulse(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        pulse(x, y);
        wait_idle();
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_diff", 64'(diff), 64'(0));
        chk("rst_borrow", 64'(borrow), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(8'h35, 8'h12);
        op(8'h00, 8'h01);
        op(8'h80, 8'h01);
        op(8'h7F, 8'hFF);
        op(8'h5A, 8'h5A);
        op(8'hC3, 8'h00);

        // Start held: results every WIDTH+2 cycles; operand change mid-RUN affects only the next one
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        repeat (4) @(negedge clk);
        a = 8'h20;
        repeat (25) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Second start during RUN is ignored
        pulse(8'hAA, 8'h55);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-RUN clears outputs at once
        pulse(8'h11, 8'h22);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_diff", 64'(diff), 64'(0));
        chk("arst_borrow", 64'(borrow), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
        chk("arst_ovf", 64'(ovf), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op(8'h03, 8'h05);

        for (int i = 0; i < 25; i++) begin
            pulse(WIDTH'($urandom), WIDTH'($urandom));
            repeat ($urandom_range(0, 12)) @(negedge clk);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
